// File: rtl/tbuf_seq_pkg.sv
// Shared definitions for the tristate-buffer drive sequencer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//   st_t       : phase encodings shared by the sequencer and any observer
//   CNT_W_DEF  : default phase-counter width
//   max3       : helper used for elaboration-time range checks
package tbuf_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SETUP = 2'd1,
      ST_DRIVE = 2'd2,
      ST_TURN  = 2'd3
   } st_t;

   localparam int CNT_W_DEF = 4;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return m;
   endfunction

endpackage

// File: rtl/tbuf_drive_seq_if.sv
// Request channel into the tristate drive sequencer (valid/ready word transfer).
// Latency: n/a (wires only).
// Backpressure: a word moves only on a clock edge where req_valid and req_ready are both high.
//   req_valid : producer has a word on req_data
//   req_ready : sequencer can take a word this cycle
//   req_data  : WIDTH-bit word, one bit per tristate lane
interface tbuf_drive_seq_if #(
   parameter int WIDTH = 1
);
   logic             req_valid;
   logic             req_ready;
   logic [WIDTH-1:0] req_data;

   modport master (
      output req_valid,
      output req_data,
      input  req_ready
   );

   modport slave (
      input  req_valid,
      input  req_data,
      output req_ready
   );
endinterface

// File: rtl/tbuf_seq_cnt.sv
// Loadable down-counter timing every phase of the drive sequencer.
// Latency: load takes effect at the next edge; zero reflects the registered value.
// Backpressure: none; counts down once per cycle and parks at zero.
//   clk, rst : clock and synchronous active-high reset (clears to zero)
//   ld       : load ld_val at the next edge (wins over the decrement)
//   ld_val   : value to load, phase length minus one
//   cnt      : current count
//   zero     : cnt == 0, marks the last cycle of the current phase
module tbuf_seq_cnt #(
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ld,
   input  logic [CNT_W-1:0] ld_val,
   output logic [CNT_W-1:0] cnt,
   output logic             zero
);

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (ld) begin
         cnt <= ld_val;
      end else if (cnt != '0) begin
         cnt <= cnt - CNT_W'(1);
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/tbuf_drive_seq.sv
// Sequencer driving A/EN of a row of tristate cells with break-before-make timing.
// Latency: accept edge to drv_en rising is SETUP_CYC+1 edges; chained words keep EN high.
// Backpressure: req_ready only in IDLE and in the last DRIVE cycle; held low in reset.
//   clk, rst          : rising-edge clock, synchronous active-high reset
//   req (slave)       : req_valid / req_ready / req_data word channel
//   drv_a  [WIDTH]    : registered, straight to cell A pins
//   drv_en            : registered, straight to the shared cell EN pins
//   busy              : registered, high whenever the sequencer is not idle
//   bus_in, rb_clr, rb_err : only with TBUF_SEQ_READBACK_EN defined; sampled cell
//                       Z nets, sticky-error clear, sticky readback mismatch flag
module tbuf_drive_seq
   import tbuf_seq_pkg::*;
#(
   parameter int WIDTH     = 1,
   parameter int SETUP_CYC = 1,
   parameter int DRIVE_CYC = 2,
   parameter int TURN_CYC  = 1,
   parameter int CNT_W     = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   tbuf_drive_seq_if.slave  req,
   output logic [WIDTH-1:0] drv_a,
   output logic             drv_en,
   output logic             busy
`ifdef TBUF_SEQ_READBACK_EN
   ,
   input  logic [WIDTH-1:0] bus_in,
   input  logic             rb_clr,
   output logic             rb_err
`endif
);

   // Parameter sanity, caught at elaboration rather than as odd waveforms later.
   if (DRIVE_CYC < 1) begin : g_bad_drive_cyc
      $error("tbuf_drive_seq: DRIVE_CYC must be >= 1");
   end
   if ((2 ** CNT_W) - 1 < max3(SETUP_CYC, DRIVE_CYC, TURN_CYC)) begin : g_bad_cnt_w
      $error("tbuf_drive_seq: CNT_W too narrow for the phase lengths");
   end

   // Counter reload values. The SETUP load is SETUP_CYC rather than SETUP_CYC-1:
   // the accept cycle itself is spent letting the new drv_a reach the cell A pins,
   // then SETUP_CYC further cycles of stable A precede EN. With SETUP_CYC=0 this
   // leaves exactly the one landing cycle, so EN rises on the edge after accept.
   localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC);
   localparam logic [CNT_W-1:0] DRIVE_LD = CNT_W'(DRIVE_CYC - 1);
   localparam logic [CNT_W-1:0] TURN_LD  = (TURN_CYC > 0) ? CNT_W'(TURN_CYC - 1) : '0;

   st_t              st;
   st_t              st_nxt;
   logic             acc;
   logic             ld;
   logic [CNT_W-1:0] ld_val;
   logic [CNT_W-1:0] cnt;
   logic             zero;
   logic             zero_nxt;

   tbuf_seq_cnt #(
      .CNT_W (CNT_W)
   ) u_cnt (
      .clk    (clk),
      .rst    (rst),
      .ld     (ld),
      .ld_val (ld_val),
      .cnt    (cnt),
      .zero   (zero)
   );

   // A transfer only happens against the registered ready, so acc is exactly
   // the handshake the producer sees.
   assign acc = req.req_valid && req.req_ready;

   // Next-phase decode; also steers the shared counter.
   always_comb begin
      st_nxt = st;
      ld     = 1'b0;
      ld_val = '0;
      case (st)
         ST_IDLE: begin
            if (acc) begin
               st_nxt = ST_SETUP;
               ld     = 1'b1;
               ld_val = SETUP_LD;
            end
         end
         ST_SETUP: begin
            if (zero) begin
               st_nxt = ST_DRIVE;
               ld     = 1'b1;
               ld_val = DRIVE_LD;
            end
         end
         ST_DRIVE: begin
            if (zero) begin
               if (acc) begin
                  // Chained word: stay in DRIVE, EN never drops, no SETUP.
                  ld     = 1'b1;
                  ld_val = DRIVE_LD;
               end else if (TURN_CYC > 0) begin
                  st_nxt = ST_TURN;
                  ld     = 1'b1;
                  ld_val = TURN_LD;
               end else begin
                  st_nxt = ST_IDLE;
               end
            end
         end
         ST_TURN: begin
            if (zero) begin
               st_nxt = ST_IDLE;
            end
         end
         default: st_nxt = ST_IDLE;
      endcase
      // Look-ahead of the counter's zero flag so req_ready can be registered
      // and still be high during the last DRIVE cycle itself.
      zero_nxt = ld ? (ld_val == '0) : (cnt <= CNT_W'(1));
   end

   // State and all outputs. drv_a moves only on a transfer, so it is never
   // disturbed when EN falls; reset drops EN and A on the same edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         st            <= ST_IDLE;
         drv_a         <= '0;
         drv_en        <= 1'b0;
         busy          <= 1'b0;
         req.req_ready <= 1'b0;
      end else begin
         st <= st_nxt;
         if (acc) begin
            drv_a <= req.req_data;
         end
         drv_en        <= (st_nxt == ST_DRIVE);
         busy          <= (st_nxt != ST_IDLE);
         req.req_ready <= (st_nxt == ST_IDLE) || ((st_nxt == ST_DRIVE) && zero_nxt);
      end
   end

`ifdef TBUF_SEQ_READBACK_EN
   // Readback compare in the last DRIVE cycle, when the cell output has had the
   // longest time to settle. Case inequality so a floating or unknown net is
   // flagged. A new mismatch outranks a clear in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         rb_err <= 1'b0;
      end else if ((st == ST_DRIVE) && zero && (bus_in !== drv_a)) begin
         rb_err <= 1'b1;
      end else if (rb_clr) begin
         rb_err <= 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_tbuf_drive_seq.sv
// Bench for tbuf_drive_seq: default-timing instance u0 and a SETUP=0/TURN=0 instance u1.
// Expected drv_a words are queued when a transfer is set up and popped when they appear.
// Optional readback checks are compiled only with TBUF_SEQ_READBACK_EN.
module tb_tbuf_drive_seq;

   localparam int W = 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   tbuf_drive_seq_if #(.WIDTH(W)) rq0 ();
   tbuf_drive_seq_if #(.WIDTH(W)) rq1 ();

   logic [W-1:0] drv_a0, drv_a1;
   logic         drv_en0, drv_en1, busy0, busy1;

`ifdef TBUF_SEQ_READBACK_EN
   logic [W-1:0] bus_in0, bus_in1;
   logic         rb_clr0, rb_clr1, rb_err0, rb_err1;
   logic         rb_z;
   // Ideal cells: Z net follows A while enabled; rb_z lets the bench float it.
   assign bus_in0 = rb_z ? 'z : drv_a0;
   assign bus_in1 = drv_a1;
`endif

   tbuf_drive_seq #(.WIDTH(W)) u0 (
      .clk    (clk),
      .rst    (rst),
      .req    (rq0),
      .drv_a  (drv_a0),
      .drv_en (drv_en0),
      .busy   (busy0)
`ifdef TBUF_SEQ_READBACK_EN
      ,
      .bus_in (bus_in0),
      .rb_clr (rb_clr0),
      .rb_err (rb_err0)
`endif
   );

   tbuf_drive_seq #(.WIDTH(W), .SETUP_CYC(0), .DRIVE_CYC(2), .TURN_CYC(0)) u1 (
      .clk    (clk),
      .rst    (rst),
      .req    (rq1),
      .drv_a  (drv_a1),
      .drv_en (drv_en1),
      .busy   (busy1)
`ifdef TBUF_SEQ_READBACK_EN
      ,
      .bus_in (bus_in1),
      .rb_clr (rb_clr1),
      .rb_err (rb_err1)
`endif
   );

   int n_cmp = 0;
   int n_bad = 0;

   logic [W-1:0] sb0[$];
   logic [W-1:0] sb1[$];

   task automatic chk(input string tag, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_bad++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   // Compare drv_a of instance sel against the oldest queued word.
   task automatic pop_chk(input string tag, input bit sel);
      logic [W-1:0] e;
      if ((sel ? sb1.size() : sb0.size()) == 0) begin
         n_cmp++;
         n_bad++;
         $error("FAIL %s: observed empty scoreboard expected a queued word", tag);
      end else begin
         e = sel ? sb1.pop_front() : sb0.pop_front();
         chk(tag, sel ? drv_a1 : drv_a0, e);
      end
   endtask

   // Step to just after the next rising edge: outputs settled, inputs safe to change.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [W-1:0] words[3];

   initial begin
      words = '{1'b0, 1'b1, 1'b0};
      rq0.req_valid = 1'b0;
      rq0.req_data  = '0;
      rq1.req_valid = 1'b0;
      rq1.req_data  = '0;
`ifdef TBUF_SEQ_READBACK_EN
      rb_clr0 = 1'b0;
      rb_clr1 = 1'b0;
      rb_z    = 1'b0;
`endif

      // Reset: two edges with rst high, then release.
      rst = 1'b1;
      tick();
      tick();
      chk("rst_ready", rq0.req_ready, 1'b0);
      chk("rst_en",    drv_en0,       1'b0);
      chk("rst_a",     drv_a0[0],     1'b0);
      chk("rst_busy",  busy0,         1'b0);
      rst = 1'b0;
      tick();
      chk("idle_ready",  rq0.req_ready, 1'b1);
      chk("idle_en",     drv_en0,       1'b0);
      chk("idle_a",      drv_a0[0],     1'b0);
      chk("idle_busy",   busy0,         1'b0);
      chk("idle_ready1", rq1.req_ready, 1'b1);

      // Single word with default timing.
      rq0.req_valid = 1'b1;
      rq0.req_data  = 1'b1;
      sb0.push_back(1'b1);
      tick();                                   // edge 1: accept
      rq0.req_valid = 1'b0;
      rq0.req_data  = 1'b0;
      pop_chk("t2_a_e1", 1'b0);
      chk("t2_en_e1",    drv_en0,       1'b0);
      chk("t2_ready_e1", rq0.req_ready, 1'b0);
      chk("t2_busy_e1",  busy0,         1'b1);
      tick();                                   // edge 2: still setting up
      chk("t2_en_e2",    drv_en0,       1'b0);
      tick();                                   // edge 3: EN rises
      chk("t2_en_e3",    drv_en0,       1'b1);
      chk("t2_ready_e3", rq0.req_ready, 1'b0);
      tick();                                   // edge 4: last drive cycle
      chk("t2_en_e4",    drv_en0,       1'b1);
      chk("t2_ready_e4", rq0.req_ready, 1'b1);
      tick();                                   // edge 5: EN falls, A held
      chk("t2_en_e5",    drv_en0,       1'b0);
      chk("t2_a_e5",     drv_a0[0],     1'b1);
      chk("t2_ready_e5", rq0.req_ready, 1'b0);
      chk("t2_busy_e5",  busy0,         1'b1);
      tick();                                   // edge 6: back to idle
      chk("t2_ready_e6", rq0.req_ready, 1'b1);
      chk("t2_busy_e6",  busy0,         1'b0);

      // Chain of three words held valid: one SETUP, one TURN, EN high 6 cycles.
      rq0.req_valid = 1'b1;
      rq0.req_data  = words[0];
      sb0.push_back(words[0]);
      tick();
      pop_chk("t3_a_acc", 1'b0);
      chk("t3_ready_acc", rq0.req_ready, 1'b0);
      rq0.req_data = words[1];                  // not ready: must be ignored
      tick();
      chk("t3_en_setup", drv_en0, 1'b0);
      chk("t3_a_setup",  drv_a0[0], words[0][0]);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("t3_en_first",    drv_en0,       1'b1);
         chk("t3_ready_first", rq0.req_ready, 1'b0);
         if (k > 0) pop_chk("t3_a_chain", 1'b0);
         tick();
         chk("t3_en_last",    drv_en0,       1'b1);
         chk("t3_ready_last", rq0.req_ready, 1'b1);
         if (k < 2) begin
            rq0.req_data = words[k+1];
            sb0.push_back(words[k+1]);
         end else begin
            rq0.req_valid = 1'b0;
         end
      end
      tick();
      chk("t3_en_turn",    drv_en0,       1'b0);
      chk("t3_a_turn",     drv_a0[0],     words[2][0]);
      chk("t3_ready_turn", rq0.req_ready, 1'b0);
      tick();
      chk("t3_ready_idle", rq0.req_ready, 1'b1);
      chk("t3_busy_idle",  busy0,         1'b0);

      // SETUP_CYC=0, TURN_CYC=0 instance: idle to idle in 3 edges.
      rq1.req_valid = 1'b1;
      rq1.req_data  = 1'b1;
      sb1.push_back(1'b1);
      tick();
      rq1.req_valid = 1'b0;
      pop_chk("t4_a_acc", 1'b1);
      chk("t4_en_acc",    drv_en1,       1'b0);
      chk("t4_ready_acc", rq1.req_ready, 1'b0);
      chk("t4_busy_acc",  busy1,         1'b1);
      tick();
      chk("t4_en_1",    drv_en1,       1'b1);
      chk("t4_ready_1", rq1.req_ready, 1'b0);
      tick();
      chk("t4_en_2",    drv_en1,       1'b1);
      chk("t4_ready_2", rq1.req_ready, 1'b1);
      tick();
      chk("t4_en_3",    drv_en1,       1'b0);
      chk("t4_ready_3", rq1.req_ready, 1'b1);
      chk("t4_busy_3",  busy1,         1'b0);

      // Reset during the first DRIVE cycle.
      rq0.req_valid = 1'b1;
      rq0.req_data  = 1'b1;
      sb0.push_back(1'b1);
      tick();
      rq0.req_valid = 1'b0;
      pop_chk("t5_a_acc", 1'b0);
      tick();
      tick();
      chk("t5_en_drive", drv_en0, 1'b1);
      rst = 1'b1;
      tick();
      chk("t5_en_rst",    drv_en0,       1'b0);
      chk("t5_a_rst",     drv_a0[0],     1'b0);
      chk("t5_ready_rst", rq0.req_ready, 1'b0);
      chk("t5_busy_rst",  busy0,         1'b0);
      rst = 1'b0;
      tick();
      chk("t5_ready_after", rq0.req_ready, 1'b1);

`ifdef TBUF_SEQ_READBACK_EN
      // Readback: healthy word leaves rb_err clear, floating net sets it.
      chk("t6_err_init", rb_err0, 1'b0);
      rq0.req_valid = 1'b1;
      rq0.req_data  = 1'b1;
      sb0.push_back(1'b1);
      tick();
      rq0.req_valid = 1'b0;
      pop_chk("t6_a_acc", 1'b0);
      tick();
      tick();
      tick();                                   // now in last DRIVE cycle
      chk("t6_ready_last", rq0.req_ready, 1'b1);
      rb_z = 1'b1;
      tick();
      rb_z = 1'b0;
      chk("t6_err_set",  rb_err0, 1'b1);
      tick();
      chk("t6_err_hold", rb_err0, 1'b1);
      rb_clr0 = 1'b1;
      tick();
      rb_clr0 = 1'b0;
      chk("t6_err_clr",  rb_err0, 1'b0);
      chk("t6_err_u1",   rb_err1, 1'b0);
`endif

      chk("sb_drained", (sb0.size() == 0) && (sb1.size() == 0), 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
